// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C master sequencer and its command handshake.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR_W,
        ST_REG,
        ST_WDATA,
        ST_RSTART,
        ST_ADDR_R,
        ST_RDATA,
        ST_STOP,
        ST_DONE
    } seq_state_t;

    typedef enum logic [1:0] {
        PH_ISSUE,
        PH_SKIP,
        PH_WAIT
    } phase_t;

    localparam logic I2C_RD = 1'b1;
    localparam logic I2C_WR = 1'b0;

endpackage

// File: rtl/i2c_cmd_handshake.sv
// One-command handshake with i2c_transaction_ctrl: ISSUE / SKIP / WAIT phases plus
// a per-command watchdog. Completion and timeout are same-cycle pulses for the sequencer.
module i2c_cmd_handshake
    import i2c_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 65535,
    parameter int unsigned TO_W        = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic cmd_req,
    input  logic ctrl_ready,
    output logic cmd_valid,
    output logic fire_c,
    output logic cmp_c,
    output logic timeout_c
);

    phase_t          phase;
    logic [TO_W-1:0] wd_cnt;
    logic            wd_hit_c;

    assign fire_c    = (phase == PH_ISSUE) && cmd_req && ctrl_ready;
    assign cmp_c     = (phase == PH_WAIT) && ctrl_ready;
    assign wd_hit_c  = (wd_cnt == TO_W'(TIMEOUT_CYC - 1));
    // Completion wins over a watchdog expiry landing in the same cycle
    assign timeout_c = (phase != PH_ISSUE) && !cmp_c && wd_hit_c;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            phase     <= PH_ISSUE;
            wd_cnt    <= '0;
            cmd_valid <= 1'b0;
        end else begin
            cmd_valid <= fire_c;
            case (phase)
                PH_ISSUE: begin
                    if (fire_c) begin
                        phase  <= PH_SKIP;
                        wd_cnt <= '0;
                    end
                end
                PH_SKIP, PH_WAIT: begin
                    if (cmp_c || timeout_c) begin
                        phase <= PH_ISSUE;
                    end else begin
                        phase  <= PH_WAIT;
                        wd_cnt <= wd_cnt + TO_W'(1);
                    end
                end
                default: phase <= PH_ISSUE;
            endcase
        end
    end

endmodule

// File: rtl/i2c_master_sequencer.sv
// Turns one register-access request into the full I2C command sequence for
// i2c_transaction_ctrl, streaming write/read bytes and reporting done/NACK/timeout.
module i2c_master_sequencer
    import i2c_pkg::*;
#(
    parameter int unsigned LEN_W       = 4,
    parameter int unsigned TIMEOUT_CYC = 65535,
    parameter int unsigned TO_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_rnw_i,
    input  logic [6:0]       req_dev_addr_i,
    input  logic [7:0]       req_reg_addr_i,
    input  logic [LEN_W-1:0] req_len_i,
    input  logic [7:0]       wr_data_i,
    input  logic             wr_valid_i,
    output logic             wr_ready_o,
    output logic [7:0]       rd_data_o,
    output logic             rd_valid_o,
    output logic             done_o,
    output logic             err_nack_o,
    output logic             err_timeout_o,
    output logic             ctrl_cmd_valid_o,
    input  logic             ctrl_ready_i,
    output logic             ctrl_start_o,
    output logic             ctrl_stop_o,
    output logic             ctrl_byte_send_o,
    output logic [7:0]       ctrl_byte_o,
    output logic             ctrl_byte_rcv_o,
    output logic             ctrl_ack_en_o,
    input  logic             ctrl_ack_i,
    input  logic [7:0]       ctrl_byte_i
);

    seq_state_t       state;
    logic             rnw;
    logic [6:0]       dev_addr;
    logic [7:0]       reg_addr;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] remaining;
    logic             cmd_req_c;
    logic             fire_c;
    logic             cmp_c;
    logic             timeout_c;
    logic             last_c;

    assign req_ready_o = (state == ST_IDLE);
    assign last_c      = (remaining == LEN_W'(1));

    // Write data bytes may only be issued once the source has a byte ready
    always_comb begin
        cmd_req_c = 1'b0;
        case (state)
            ST_START, ST_ADDR_W, ST_REG, ST_RSTART,
            ST_ADDR_R, ST_RDATA, ST_STOP: cmd_req_c = 1'b1;
            ST_WDATA:                     cmd_req_c = wr_valid_i;
            default:                      cmd_req_c = 1'b0;
        endcase
    end

    i2c_cmd_handshake #(
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .TO_W       (TO_W)
    ) u_handshake (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .cmd_req   (cmd_req_c),
        .ctrl_ready(ctrl_ready_i),
        .cmd_valid (ctrl_cmd_valid_o),
        .fire_c    (fire_c),
        .cmp_c     (cmp_c),
        .timeout_c (timeout_c)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state            <= ST_IDLE;
            rnw              <= 1'b0;
            dev_addr         <= '0;
            reg_addr         <= '0;
            len              <= '0;
            remaining        <= '0;
            ctrl_start_o     <= 1'b0;
            ctrl_stop_o      <= 1'b0;
            ctrl_byte_send_o <= 1'b0;
            ctrl_byte_o      <= '0;
            ctrl_byte_rcv_o  <= 1'b0;
            ctrl_ack_en_o    <= 1'b0;
            wr_ready_o       <= 1'b0;
            rd_data_o        <= '0;
            rd_valid_o       <= 1'b0;
            done_o           <= 1'b0;
            err_nack_o       <= 1'b0;
            err_timeout_o    <= 1'b0;
        end else begin
            ctrl_start_o     <= 1'b0;
            ctrl_stop_o      <= 1'b0;
            ctrl_byte_send_o <= 1'b0;
            ctrl_byte_rcv_o  <= 1'b0;
            ctrl_ack_en_o    <= 1'b0;
            wr_ready_o       <= 1'b0;
            rd_valid_o       <= 1'b0;
            done_o           <= 1'b0;

            // Command strobes, launched together with ctrl_cmd_valid_o
            if (fire_c) begin
                case (state)
                    ST_START, ST_RSTART: ctrl_start_o <= 1'b1;
                    ST_ADDR_W: begin
                        ctrl_byte_send_o <= 1'b1;
                        ctrl_byte_o      <= {dev_addr, I2C_WR};
                    end
                    ST_REG: begin
                        ctrl_byte_send_o <= 1'b1;
                        ctrl_byte_o      <= reg_addr;
                    end
                    ST_WDATA: begin
                        ctrl_byte_send_o <= 1'b1;
                        ctrl_byte_o      <= wr_data_i;
                        wr_ready_o       <= 1'b1;
                    end
                    ST_ADDR_R: begin
                        ctrl_byte_send_o <= 1'b1;
                        ctrl_byte_o      <= {dev_addr, I2C_RD};
                    end
                    ST_RDATA: begin
                        ctrl_byte_rcv_o <= 1'b1;
                        ctrl_ack_en_o   <= !last_c;
                    end
                    ST_STOP: ctrl_stop_o <= 1'b1;
                    default: ;
                endcase
            end

            if (timeout_c) begin
                err_timeout_o <= 1'b1;
                done_o        <= 1'b1;
                state         <= ST_DONE;
            end else if (state == ST_IDLE) begin
                if (req_valid_i) begin
                    rnw           <= req_rnw_i;
                    dev_addr      <= req_dev_addr_i;
                    reg_addr      <= req_reg_addr_i;
                    len           <= req_len_i;
                    remaining     <= req_len_i;
                    err_nack_o    <= 1'b0;
                    err_timeout_o <= 1'b0;
                    state         <= ST_START;
                end
            end else if (state == ST_DONE) begin
                state <= ST_IDLE;
            end else if (cmp_c) begin
                case (state)
                    ST_START:  state <= ST_ADDR_W;
                    ST_ADDR_W: begin
                        err_nack_o <= ctrl_ack_i;
                        state      <= ctrl_ack_i ? ST_STOP : ST_REG;
                    end
                    ST_REG: begin
                        err_nack_o <= ctrl_ack_i;
                        if (ctrl_ack_i || (len == '0)) begin
                            state <= ST_STOP;
                        end else begin
                            state <= (rnw == I2C_RD) ? ST_RSTART : ST_WDATA;
                        end
                    end
                    ST_WDATA: begin
                        err_nack_o <= ctrl_ack_i;
                        remaining  <= remaining - LEN_W'(1);
                        if (ctrl_ack_i || last_c) begin
                            state <= ST_STOP;
                        end
                    end
                    ST_RSTART: state <= ST_ADDR_R;
                    ST_ADDR_R: begin
                        err_nack_o <= ctrl_ack_i;
                        state      <= ctrl_ack_i ? ST_STOP : ST_RDATA;
                    end
                    // Controller ack after a received byte is our own ACK/NACK; ignore it
                    ST_RDATA: begin
                        rd_data_o  <= ctrl_byte_i;
                        rd_valid_o <= 1'b1;
                        remaining  <= remaining - LEN_W'(1);
                        if (last_c) begin
                            state <= ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        done_o <= 1'b1;
                        state  <= ST_DONE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_sequencer.sv
// Randomized self-checking bench for i2c_master_sequencer with a behavioural
// transaction controller and a command-list reference model.
module tb_i2c_master_sequencer;

    localparam int unsigned LEN_W     = 4;
    localparam int unsigned TO_CYC    = 100;
    localparam int          CMD_START = 'h100;
    localparam int          CMD_STOP  = 'h200;
    localparam int          CMD_RCV   = 'h300;
    localparam int          CMD_BAD   = 'hF00;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             req_valid_i = 1'b0;
    logic             req_ready_o;
    logic             req_rnw_i = 1'b0;
    logic [6:0]       req_dev_addr_i = '0;
    logic [7:0]       req_reg_addr_i = '0;
    logic [LEN_W-1:0] req_len_i = '0;
    logic [7:0]       wr_data_i = '0;
    logic             wr_valid_i = 1'b0;
    logic             wr_ready_o;
    logic [7:0]       rd_data_o;
    logic             rd_valid_o;
    logic             done_o;
    logic             err_nack_o;
    logic             err_timeout_o;
    logic             ctrl_cmd_valid_o;
    logic             ctrl_ready_i = 1'b1;
    logic             ctrl_start_o;
    logic             ctrl_stop_o;
    logic             ctrl_byte_send_o;
    logic [7:0]       ctrl_byte_o;
    logic             ctrl_byte_rcv_o;
    logic             ctrl_ack_en_o;
    logic             ctrl_ack_i = 1'b0;
    logic [7:0]       ctrl_byte_i = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    i2c_master_sequencer #(
        .LEN_W      (LEN_W),
        .TIMEOUT_CYC(TO_CYC),
        .TO_W       (16)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_rnw_i       (req_rnw_i),
        .req_dev_addr_i  (req_dev_addr_i),
        .req_reg_addr_i  (req_reg_addr_i),
        .req_len_i       (req_len_i),
        .wr_data_i       (wr_data_i),
        .wr_valid_i      (wr_valid_i),
        .wr_ready_o      (wr_ready_o),
        .rd_data_o       (rd_data_o),
        .rd_valid_o      (rd_valid_o),
        .done_o          (done_o),
        .err_nack_o      (err_nack_o),
        .err_timeout_o   (err_timeout_o),
        .ctrl_cmd_valid_o(ctrl_cmd_valid_o),
        .ctrl_ready_i    (ctrl_ready_i),
        .ctrl_start_o    (ctrl_start_o),
        .ctrl_stop_o     (ctrl_stop_o),
        .ctrl_byte_send_o(ctrl_byte_send_o),
        .ctrl_byte_o     (ctrl_byte_o),
        .ctrl_byte_rcv_o (ctrl_byte_rcv_o),
        .ctrl_ack_en_o   (ctrl_ack_en_o),
        .ctrl_ack_i      (ctrl_ack_i),
        .ctrl_byte_i     (ctrl_byte_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({ctrl_cmd_valid_o, ctrl_start_o, ctrl_stop_o, ctrl_byte_send_o, ctrl_byte_o,
                    ctrl_byte_rcv_o, ctrl_ack_en_o, wr_ready_o, rd_data_o, rd_valid_o, done_o,
                    err_nack_o, err_timeout_o});
    endfunction

    // Behavioural transaction controller: logs commands, goes busy a few cycles
    int         got_cmds[$];
    logic [7:0] rd_stream[$];
    int         send_cnt = 0;
    int         rcv_cnt = 0;
    int         busy = 0;
    int         send_base = 0;
    int         nack_idx = -1;
    bit         hang = 1'b0;

    always @(posedge clk_i) begin
        int ns;
        if (rst_i) begin
            ctrl_ready_i <= 1'b1;
            busy = 0;
        end else if (ctrl_cmd_valid_o) begin
            ns = int'(ctrl_start_o) + int'(ctrl_stop_o) + int'(ctrl_byte_send_o) + int'(ctrl_byte_rcv_o);
            if (ns != 1) begin
                got_cmds.push_back(CMD_BAD);
            end else if (ctrl_start_o) begin
                got_cmds.push_back(CMD_START);
                ctrl_ack_i <= 1'b0;
            end else if (ctrl_stop_o) begin
                got_cmds.push_back(CMD_STOP);
                ctrl_ack_i <= 1'b0;
            end else if (ctrl_byte_send_o) begin
                got_cmds.push_back(int'(ctrl_byte_o));
                ctrl_ack_i <= ((send_cnt - send_base) == nack_idx);
                send_cnt++;
            end else begin
                got_cmds.push_back(CMD_RCV | int'(ctrl_ack_en_o));
                ctrl_byte_i <= (rcv_cnt < rd_stream.size()) ? rd_stream[rcv_cnt] : 8'h00;
                ctrl_ack_i  <= 1'($urandom_range(0, 1));
                rcv_cnt++;
            end
            ctrl_ready_i <= 1'b0;
            busy = int'($urandom_range(0, 3));
        end else if (!ctrl_ready_i && !hang) begin
            if (busy == 0) ctrl_ready_i <= 1'b1;
            else busy--;
        end
    end

    // Output monitor and write-byte source with random gaps
    logic [7:0] wr_stream[$];
    logic [7:0] rd_got[$];
    int         wr_cnt = 0;
    int         widx = 0;

    always @(negedge clk_i) begin
        if (wr_ready_o) begin
            wr_cnt++;
            widx++;
        end
        if (rd_valid_o) rd_got.push_back(rd_data_o);
        if (widx < wr_stream.size() && $urandom_range(0, 3) != 0) begin
            wr_valid_i = 1'b1;
            wr_data_i  = wr_stream[widx];
        end else begin
            wr_valid_i = 1'b0;
            wr_data_i  = 8'($urandom);
        end
    end

    task automatic run_txn(input logic rnw, input logic [6:0] dev, input logic [7:0] rg,
                           input logic [LEN_W-1:0] len, input int nk, input bit hang_en);
        int         cmd_base, rd_base, wr_base, wr_start, rd_start, si, exp_wr, cyc, n;
        bit         nk_hit;
        int         plan[$];
        int         exp_q[$];
        logic [7:0] exp_rd[$];

        @(negedge clk_i);
        cmd_base  = got_cmds.size();
        rd_base   = rd_got.size();
        wr_base   = wr_cnt;
        wr_start  = widx;
        rd_start  = rcv_cnt;
        nack_idx  = nk;
        send_base = send_cnt;
        hang      = hang_en;

        // Reference: the command list the request implies, cut short at the first NACK
        plan.push_back(CMD_START);
        plan.push_back(int'({dev, 1'b0}));
        plan.push_back(int'(rg));
        if (len != '0) begin
            if (!rnw) begin
                for (int i = 0; i < int'(len); i++) plan.push_back(int'(wr_stream[wr_start + i]));
            end else begin
                plan.push_back(CMD_START);
                plan.push_back(int'({dev, 1'b1}));
                for (int i = 0; i < int'(len); i++) plan.push_back(CMD_RCV | ((i != int'(len) - 1) ? 1 : 0));
            end
        end
        nk_hit = 1'b0;
        exp_wr = 0;
        si     = 0;
        if (hang_en) begin
            exp_q.push_back(CMD_START);
        end else begin
            foreach (plan[k]) begin
                exp_q.push_back(plan[k]);
                if (plan[k] < 256) begin
                    if (!rnw && si >= 2) exp_wr++;
                    if (si == nk) begin
                        nk_hit = 1'b1;
                        break;
                    end
                    si++;
                end else if (plan[k] == CMD_RCV || plan[k] == (CMD_RCV | 1)) begin
                    exp_rd.push_back(rd_stream[rd_start + exp_rd.size()]);
                end
            end
            exp_q.push_back(CMD_STOP);
        end

        check("req_ready_idle", 32'(req_ready_o), 32'd1);
        req_valid_i    = 1'b1;
        req_rnw_i      = rnw;
        req_dev_addr_i = dev;
        req_reg_addr_i = rg;
        req_len_i      = len;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        check("errs_cleared", 32'({err_nack_o, err_timeout_o}), 32'd0);
        check("busy_not_ready", 32'(req_ready_o), 32'd0);

        cyc = 0;
        while (!done_o && cyc < 3000) begin
            @(negedge clk_i);
            cyc++;
        end
        check("done_seen", 32'(done_o), 32'd1);
        check("ready_in_done", 32'(req_ready_o), 32'd0);
        @(negedge clk_i);
        check("ready_after_done", 32'({req_ready_o, done_o}), 32'b10);

        check("n_cmds", 32'(got_cmds.size() - cmd_base), 32'(exp_q.size()));
        n = (got_cmds.size() - cmd_base < exp_q.size()) ? got_cmds.size() - cmd_base : exp_q.size();
        for (int i = 0; i < n; i++) check($sformatf("cmd%0d", i), 32'(got_cmds[cmd_base + i]), 32'(exp_q[i]));
        check("wr_pulses", 32'(wr_cnt - wr_base), 32'(exp_wr));
        check("n_rd", 32'(rd_got.size() - rd_base), 32'(exp_rd.size()));
        n = (rd_got.size() - rd_base < exp_rd.size()) ? rd_got.size() - rd_base : exp_rd.size();
        for (int i = 0; i < n; i++) check($sformatf("rd%0d", i), 32'(rd_got[rd_base + i]), 32'(exp_rd[i]));
        check("err_nack", 32'(err_nack_o), 32'(nk_hit));
        check("err_timeout", 32'(err_timeout_o), 32'(hang_en));
        hang = 1'b0;
    endtask

    initial begin
        int         cyc, rd_start, nsend, nk;
        logic       rnw;
        logic [3:0] len;

        repeat (3) @(negedge clk_i);
        check("reset_outs", all_outs(), 32'd0);
        check("reset_ready", 32'(req_ready_o), 32'd1);
        rst_i = 1'b0;

        wr_stream.push_back(8'hA5);
        wr_stream.push_back(8'h3C);
        run_txn(1'b0, 7'h50, 8'h10, 4'd2, -1, 1'b0);

        rd_stream.push_back(8'h11);
        rd_stream.push_back(8'h22);
        rd_stream.push_back(8'h33);
        run_txn(1'b1, 7'h50, 8'h20, 4'd3, -1, 1'b0);

        wr_stream.push_back(8'h5A);
        wr_stream.push_back(8'hC3);
        run_txn(1'b0, 7'h51, 8'h10, 4'd2, 0, 1'b0);

        run_txn(1'b0, 7'h50, 8'h05, 4'd0, -1, 1'b0);
        run_txn(1'b1, 7'h50, 8'h05, 4'd0, -1, 1'b0);

        wr_stream.push_back(8'h77);
        run_txn(1'b0, 7'h50, 8'h10, 4'd1, -1, 1'b1);
        run_txn(1'b1, 7'h50, 8'h10, 4'd0, -1, 1'b0);

        // Reset while the second read byte is in flight
        for (int i = 0; i < 4; i++) rd_stream.push_back(8'($urandom));
        rd_start = rcv_cnt;
        @(negedge clk_i);
        req_valid_i    = 1'b1;
        req_rnw_i      = 1'b1;
        req_dev_addr_i = 7'h2A;
        req_reg_addr_i = 8'h40;
        req_len_i      = 4'd4;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        cyc = 0;
        while (rcv_cnt - rd_start < 2 && cyc < 3000) begin
            @(negedge clk_i);
            cyc++;
        end
        check("reached_rdata2", 32'(rcv_cnt - rd_start), 32'd2);
        #2 rst_i = 1'b1;
        #1;
        check("midrst_outs", all_outs(), 32'd0);
        check("midrst_ready", 32'(req_ready_o), 32'd1);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("post_rst_ready", 32'(req_ready_o), 32'd1);
        run_txn(1'b1, 7'h2A, 8'h41, 4'd2, -1, 1'b0);

        for (int t = 0; t < 40; t++) begin
            rnw   = 1'($urandom_range(0, 1));
            len   = 4'($urandom_range(0, 6));
            nsend = rnw ? ((len != 0) ? 3 : 2) : 2 + int'(len);
            nk    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nsend - 1)) : -1;
            for (int i = 0; i < int'(len); i++) begin
                if (rnw) rd_stream.push_back(8'($urandom));
                else     wr_stream.push_back(8'($urandom));
            end
            run_txn(rnw, 7'($urandom), 8'($urandom), len, nk, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_master_sequencer.md
Name: i2c_master_sequencer

Overview:
- Transaction-level sequencer that sits on top of i2c_transaction_ctrl and drives it through its command handshake.
- Converts one user request into the full I2C register-access sequence:
  - Write: START, device address + W, register address, N data bytes, STOP.
  - Read: START, device address + W, register address, repeated START, device address + R, N data bytes, STOP.
- Checks ACK after every sent byte, streams write data in and read data out, and reports done, NACK and timeout status.

Parameters:
- LEN_W, 4: width of the byte-count field. Maximum transfer is 2^LEN_W-1 bytes.
- TIMEOUT_CYC, 65535: per-command watchdog, in clk_i cycles, waiting for the controller to return ready.
- TO_W, 16: watchdog counter width. Must satisfy 2^TO_W > TIMEOUT_CYC.

Ports:
- clk_i  in  1  single clock
- rst_i  in  1  reset, asynchronous, active-high
- req_valid_i  in  1  request strobe
- req_ready_o  out  1  sequencer idle; request accepted when valid&&ready
- req_rnw_i  in  1  1=read, 0=write
- req_dev_addr_i  in  7  7-bit slave address
- req_reg_addr_i  in  8  register address
- req_len_i  in  LEN_W  data byte count (0 allowed)
- wr_data_i  in  8  write byte
- wr_valid_i  in  1  write byte available
- wr_ready_o  out  1  1-cycle pulse: wr_data_i consumed
- rd_data_o  out  8  received byte
- rd_valid_o  out  1  1-cycle pulse: rd_data_o valid
- done_o  out  1  1-cycle pulse at end of transaction
- err_nack_o  out  1  sticky; cleared at next accepted request
- err_timeout_o  out  1  sticky; cleared at next accepted request
- ctrl_cmd_valid_o  out  1  to controller cmd_valid_i
- ctrl_ready_i  in  1  from controller ready_o
- ctrl_start_o  out  1  to controller start_send_i
- ctrl_stop_o  out  1  to controller stop_send_i
- ctrl_byte_send_o  out  1  to controller byte_send_i
- ctrl_byte_o  out  8  to controller byte_i
- ctrl_byte_rcv_o  out  1  to controller byte_rcv_i
- ctrl_ack_en_o  out  1  to controller ack_en_i
- ctrl_ack_i  in  1  from controller ack_received_o (raw SDA level: 0=ACK, 1=NACK)
- ctrl_byte_i  in  8  from controller byte_o

Behaviour:
- Reset: all outputs 0 and state IDLE, except req_ready_o, which is 1 whenever state==IDLE (combinational), so it reads 1 after reset.
- Request capture: on valid&&ready, latch rnw, dev, reg and len; clear both error flags.
- Sequence states: IDLE, START, ADDR_W, REG, WDATA, RSTART, ADDR_R, RDATA, STOP, DONE.
- Command phases within each command state:
  - ISSUE: wait for ctrl_ready_i=1, then assert ctrl_cmd_valid_o and exactly one command strobe for one cycle.
  - SKIP: one mandatory cycle, because the controller's ready is its state==IDLE and drops one cycle after the command.
  - WAIT: wait for ctrl_ready_i=1. That cycle is completion; ctrl_ack_i and ctrl_byte_i are sampled there.
- Command strobes per state:
  - START and RSTART: ctrl_start_o.
  - ADDR_W: ctrl_byte_send_o with byte {dev,1'b0}.
  - ADDR_R: ctrl_byte_send_o with byte {dev,1'b1}.
  - REG: ctrl_byte_send_o with byte reg.
  - WDATA: ctrl_byte_send_o with byte wr_data_i.
  - RDATA: ctrl_byte_rcv_o; ctrl_ack_en_o=1 except on the last byte, where it is 0 (master NACK).
  - STOP: ctrl_stop_o.
- Transitions:
  - START→ADDR_W→REG.
  - REG→WDATA if write and len>0.
  - REG→RSTART if read and len>0.
  - REG→STOP if len==0 (pointer-only access, for either rnw).
  - WDATA loops until remaining==0, then →STOP.
  - RSTART→ADDR_R→RDATA.
  - RDATA loops until remaining==0, then →STOP.
  - STOP→DONE→IDLE.
- WDATA issue: ISSUE also requires wr_valid_i=1. wr_ready_o pulses in the same cycle as ctrl_cmd_valid_o. No wr_valid_i means SCL is held idle by the controller; there is no timeout in that case.
- RDATA completion: rd_data_o←ctrl_byte_i and rd_valid_o pulses one cycle after completion.
- Remaining counter: LEN_W bits, decremented at each data-byte completion. It never wraps, because len==0 skips the data phase.
- NACK: ctrl_ack_i=1 at completion of ADDR_W, REG, WDATA or ADDR_R sets err_nack_o and goes directly to STOP. The remaining data phase is abandoned. The NACK flagged by the controller after an RDATA byte is ignored.
- Watchdog: counts cycles in SKIP/WAIT. On reaching TIMEOUT_CYC it sets err_timeout_o and goes to DONE, with no STOP issued.
- done_o pulses in DONE, one cycle before req_ready_o rises, regardless of errors.
- Reset mid-transaction: immediate return to IDLE. The bus is left as the controller's own reset leaves it.

Decomposition:
- Package i2c_pkg:
  - Sequencer state enum.
  - Phase enum: ISSUE, SKIP, WAIT.
  - Constants I2C_RD=1'b1 and I2C_WR=1'b0.
- One natural sub-module, i2c_cmd_handshake: implements the ISSUE/SKIP/WAIT phase and the watchdog, and outputs a completion pulse and a timeout pulse. The top level holds the transaction FSM and counters.

Test Plan:
- Write with dev=0x50, reg=0x10, len=2, data 0xA5,0x3C, model always ACKs → controller command order START, 0xA0, 0x10, 0xA5, 0x3C, STOP; 2 wr_ready_o pulses; done_o=1; err_nack_o=0.
- Read with dev=0x50, reg=0x20, len=3, model returns 0x11,0x22,0x33 → command order START, 0xA0, 0x20, START, 0xA1, RCV×3 with ack_en 1,1,0, STOP; rd_data_o 0x11,0x22,0x33.
- Write to dev=0x51 with model NACK on the address → START, 0xA2, STOP only; err_nack_o=1; no wr_ready_o pulse; done_o=1.
- len=0 write and len=0 read to reg=0x05 → START, addr W, 0x05, STOP, with no RSTART in the read case.
- Model holds ctrl_ready_i=0 for TIMEOUT_CYC (run with TIMEOUT_CYC set to 100) → err_timeout_o=1; done_o=1; next accepted request clears the flag.
- Assert rst_i during RDATA byte 2 → all outputs 0 immediately; req_ready_o=1 after release; a new request completes normally.
